// File: rtl/button_debounce_multi.sv
// rtl/button_debounce_multi.sv - multi-channel button synchroniser, debouncer and press classifier
//
// Purpose:
//   Every board button goes through the same per-channel pipeline:
//   polarity normalisation -> 2-flop synchroniser -> stable-time debouncer
//   -> press/release edge pulses -> long-press and auto-repeat pulses.
//   Channels share nothing except clk and rst.
//
// Parameters:
//   N_CH        number of button channels
//   CNT_MAX     stable cycles before the debounced level follows the pin (>= 1)
//   ACTIVE_LOW  per-channel mask, bit=1 means the pin reads 0 when pressed
//   LONG_CNT    held cycles after the press pulse before btn_long fires (>= 1)
//   REPEAT_CNT  cycles between auto-repeat pulses after btn_long, 0 = no repeat
//
// Ports:
//   clk          system clock
//   rst          asynchronous active-high reset
//   btn_in       raw button pins, asynchronous to clk
//   btn_level    debounced level, 1 = pressed
//   btn_press    one-cycle pulse in the first cycle btn_level is 1
//   btn_release  one-cycle pulse in the first cycle btn_level is 0 again
//   btn_long     one-cycle pulse LONG_CNT cycles after btn_press while held
//   btn_repeat   one-cycle pulse every REPEAT_CNT cycles after btn_long while held

module button_debounce_multi #(
    parameter int              N_CH       = 5,
    parameter int              CNT_MAX    = 1000000,
    parameter logic [N_CH-1:0] ACTIVE_LOW = {N_CH{1'b0}},
    parameter int              LONG_CNT   = 50000000,
    parameter int              REPEAT_CNT = 10000000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] btn_in,
    output logic [N_CH-1:0] btn_level,
    output logic [N_CH-1:0] btn_press,
    output logic [N_CH-1:0] btn_release,
    output logic [N_CH-1:0] btn_long,
    output logic [N_CH-1:0] btn_repeat
);

    localparam int CW = $clog2(CNT_MAX + 1);
    localparam int HW = $clog2(LONG_CNT + 1);
    localparam int RW = (REPEAT_CNT > 1) ? $clog2(REPEAT_CNT) : 1;

    localparam logic [CW-1:0] CNT_LAST  = CW'(CNT_MAX - 1);
    localparam logic [HW-1:0] LONG_LAST = HW'(LONG_CNT - 1);
    localparam logic [HW-1:0] HOLD_SAT  = HW'(LONG_CNT);
    localparam logic [RW-1:0] REP_LAST  = RW'((REPEAT_CNT == 0) ? 0 : REPEAT_CNT - 1);
    localparam bit            REP_EN    = (REPEAT_CNT != 0);

    for (genvar i = 0; i < N_CH; i++) begin : g_ch

        logic          raw;
        logic          sync_a;
        logic          sync_b;
        logic [CW-1:0] cnt_q;
        logic          level_q;
        logic          level_d;
        logic          flip;
        logic          press_q;
        logic          release_q;
        logic [HW-1:0] hold_q;
        logic          long_hit;
        logic          long_q;
        logic          armed_q;
        logic [RW-1:0] rep_q;
        logic          repeat_q;

        // Pressed is always 1 from here on.
        assign raw = btn_in[i] ^ ACTIVE_LOW[i];

        // Reset value 0 is the released state, so a button held through
        // reset is seen as a fresh press and never as a release.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                sync_a <= 1'b0;
                sync_b <= 1'b0;
            end else begin
                sync_a <= raw;
                sync_b <= sync_a;
            end
        end

        // The level only follows the synchronised pin after it has
        // disagreed for CNT_MAX consecutive cycles; any return clears the count.
        assign flip    = (sync_b != level_q) && (cnt_q == CNT_LAST);
        assign level_d = flip ? sync_b : level_q;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cnt_q     <= '0;
                level_q   <= 1'b0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
            end else begin
                if ((sync_b == level_q) || flip) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
                level_q   <= level_d;
                press_q   <= flip & sync_b;
                release_q <= flip & ~sync_b;
            end
        end

        // hold_q equals k in cycle t0+k (t0 = press cycle) and saturates
        // at LONG_CNT, so btn_long can fire only once per hold.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                hold_q <= '0;
            end else if (!level_d || !level_q) begin
                hold_q <= '0;
            end else if (hold_q != HOLD_SAT) begin
                hold_q <= hold_q + 1'b1;
            end
        end

        // Qualified with level_d so a release landing in cycle t0+LONG_CNT
        // suppresses the pulse.
        assign long_hit = level_d && level_q && (hold_q == LONG_LAST);

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                long_q <= 1'b0;
            end else begin
                long_q <= long_hit;
            end
        end

        // After btn_long the repeat counter runs with rep_q = 0 in the
        // long cycle, pulsing each time it wraps.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                armed_q  <= 1'b0;
                rep_q    <= '0;
                repeat_q <= 1'b0;
            end else begin
                repeat_q <= 1'b0;
                if (!level_d) begin
                    armed_q <= 1'b0;
                    rep_q   <= '0;
                end else if (long_hit) begin
                    armed_q <= REP_EN;
                    rep_q   <= '0;
                end else if (armed_q) begin
                    if (rep_q == REP_LAST) begin
                        rep_q    <= '0;
                        repeat_q <= 1'b1;
                    end else begin
                        rep_q <= rep_q + 1'b1;
                    end
                end
            end
        end

        assign btn_level[i]   = level_q;
        assign btn_press[i]   = press_q;
        assign btn_release[i] = release_q;
        assign btn_long[i]    = long_q;
        assign btn_repeat[i]  = repeat_q;
    end

endmodule

// File: tb/tb_button_debounce_multi.sv
// tb/tb_button_debounce_multi.sv - directed self-checking bench for button_debounce_multi

module tb_button_debounce_multi;

    logic       clk;
    logic       rst;
    logic [1:0] btn_in;
    logic [1:0] btn_level;
    logic [1:0] btn_press;
    logic [1:0] btn_release;
    logic [1:0] btn_long;
    logic [1:0] btn_repeat;

    int compared;
    int mismatched;

    button_debounce_multi #(
        .N_CH       (2),
        .CNT_MAX    (4),
        .ACTIVE_LOW (2'b10),
        .LONG_CNT   (20),
        .REPEAT_CNT (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .btn_in      (btn_in),
        .btn_level   (btn_level),
        .btn_press   (btn_press),
        .btn_release (btn_release),
        .btn_long    (btn_long),
        .btn_repeat  (btn_repeat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [9:0] pack(input logic [1:0] l, input logic [1:0] p,
                                        input logic [1:0] r, input logic [1:0] g,
                                        input logic [1:0] t);
        return {l, p, r, g, t};
    endfunction

    task automatic chk(input string tag, input int k, input logic [9:0] exp);
        logic [9:0] obs;
        obs = {btn_level, btn_press, btn_release, btn_long, btn_repeat};
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s k=%0d observed lvl/prs/rel/lng/rep=%b expected=%b", tag, k, obs, exp);
        end
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        rst        = 1'b1;
        btn_in     = 2'b10;
        #1;
        chk("reset_async", 0, 10'b0);
        for (int k = 1; k <= 3; k++) begin
            step();
            chk("reset_hold", k, 10'b0);
        end
        rst = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            step();
            chk("idle", k, 10'b0);
        end

        // Clean press on ch0, held 10 cycles, then released.
        btn_in[0] = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            step();
            chk("clean_press", k, pack({1'b0, k >= 6}, {1'b0, k == 6}, 2'b00, 2'b00, 2'b00));
        end
        btn_in[0] = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            step();
            chk("clean_release", k, pack({1'b0, k < 6}, 2'b00, {1'b0, k == 6}, 2'b00, 2'b00));
        end

        // Bounce: high 3 / low 1 never qualifies.
        for (int b = 0; b < 4; b++) begin
            btn_in[0] = 1'b1;
            for (int k = 1; k <= 3; k++) begin
                step();
                chk("bounce_hi", b * 4 + k, 10'b0);
            end
            btn_in[0] = 1'b0;
            step();
            chk("bounce_lo", b * 4 + 4, 10'b0);
        end
        btn_in[0] = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            step();
            chk("bounce_settle", k, pack({1'b0, k >= 6}, {1'b0, k == 6}, 2'b00, 2'b00, 2'b00));
        end
        btn_in[0] = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            step();
            chk("bounce_release", k, pack({1'b0, k < 6}, 2'b00, {1'b0, k == 6}, 2'b00, 2'b00));
        end

        // Long hold: t0 at k=6, long at t0+20, repeats at t0+28/36/44.
        btn_in[0] = 1'b1;
        for (int k = 1; k <= 51; k++) begin
            step();
            chk("long_hold", k, pack({1'b0, k >= 6}, {1'b0, k == 6}, 2'b00, {1'b0, k == 26},
                                     {1'b0, (k == 34) || (k == 42) || (k == 50)}));
        end
        btn_in[0] = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            step();
            chk("long_release", k, pack({1'b0, k < 6}, 2'b00, {1'b0, k == 6}, 2'b00, 2'b00));
        end

        // Active-low ch1 pressed two cycles after ch0; both released together.
        btn_in[0] = 1'b1;
        for (int k = 1; k <= 37; k++) begin
            if (k == 3) btn_in[1] = 1'b0;
            if (k == 28) btn_in = 2'b10;
            step();
            chk("dual", k, pack({(k >= 8) && (k <= 32), (k >= 6) && (k <= 32)},
                                {k == 8, k == 6},
                                {k == 33, k == 33},
                                {k == 28, k == 26},
                                2'b00));
        end

        // Reset at t0+15 while ch0 held.
        btn_in[0] = 1'b1;
        for (int k = 1; k <= 21; k++) begin
            step();
            chk("pre_reset", k, pack({1'b0, k >= 6}, {1'b0, k == 6}, 2'b00, 2'b00, 2'b00));
        end
        rst = 1'b1;
        #1;
        chk("reset_mid", 0, 10'b0);
        for (int k = 1; k <= 2; k++) begin
            step();
            chk("reset_mid_hold", k, 10'b0);
        end
        rst = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            if (k == 31) btn_in[0] = 1'b0;
            step();
            chk("post_reset", k, pack({1'b0, (k >= 6) && (k <= 35)}, {1'b0, k == 6},
                                      {1'b0, k == 36}, {1'b0, k == 26}, {1'b0, k == 34}));
        end

        // Release landing exactly in cycle t0+20 suppresses btn_long.
        btn_in[0] = 1'b1;
        for (int k = 1; k <= 32; k++) begin
            if (k == 21) btn_in[0] = 1'b0;
            step();
            chk("release_at_long", k, pack({1'b0, (k >= 6) && (k <= 25)}, {1'b0, k == 6},
                                           {1'b0, k == 26}, 2'b00, 2'b00));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/button_debounce_multi.md
Name: button_debounce_multi

Overview:
- Multi-channel push-button front end: synchroniser, debouncer and press classifier for every board button in one block.
- Per channel it outputs a clean debounced level plus one-cycle pulses for press, release, long-press and auto-repeat.
- Sits between board pins and the menu/input FSMs of the matrix calculator, replacing per-button debounce instances and the separate edge detectors after them.

Parameters:
- N_CH, 5, number of button channels.
- CNT_MAX, 1000000, stable cycles required before the debounced level changes (10 ms @ 100 MHz); legal range >= 1.
- ACTIVE_LOW, {N_CH{1'b0}}, per-channel mask; bit=1 means the pin reads 0 when pressed.
- LONG_CNT, 50000000, held cycles before btn_long fires (0.5 s); legal range >= 1.
- REPEAT_CNT, 10000000, auto-repeat period after btn_long; 0 disables repeat.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- btn_in  input  N_CH  raw button pins, asynchronous to clk.
- btn_level  output  N_CH  debounced level, 1 = pressed (polarity already normalised).
- btn_press  output  N_CH  one-cycle pulse on a debounced press.
- btn_release  output  N_CH  one-cycle pulse on a debounced release.
- btn_long  output  N_CH  one-cycle pulse when the button has been held for LONG_CNT cycles.
- btn_repeat  output  N_CH  one-cycle pulse every REPEAT_CNT cycles after btn_long while still held.

Behaviour:
- Interface: one clock, clk. Reset rst is asynchronous and active-high. While rst=1, all state and all outputs are 0, with no pulses.
- Channels are fully independent; all per-channel logic is replicated N_CH times. No channel influences another.
- Normalisation: raw_i = btn_in[i] XOR ACTIVE_LOW[i], so that pressed = 1.
- Sync: 2-flop synchroniser on raw_i. Both flops reset to 0, the released state.
- Debounce counter:
  - Width $clog2(CNT_MAX+1); state register = btn_level[i].
  - If sync == state, the counter clears.
  - Otherwise the counter increments. On the edge where the counter equals CNT_MAX-1, state <= sync and the counter clears.
  - A bounce (sync returning to state) clears the counter at any count.
- Latency: a clean btn_in transition becomes visible on btn_level after the (CNT_MAX+2)th rising edge following the transition. Shorter glitches never reach btn_level.
- Press/release:
  - btn_press is 1 exactly in the first cycle btn_level[i] is 1.
  - btn_release is 1 exactly in the first cycle btn_level[i] is 0 after being 1.
  - Both are registered alongside the level, so they are never both 1 on the same channel.
- Hold counter:
  - Counts cycles while btn_level=1 and clears when btn_level=0.
  - Saturates; it never wraps during an arbitrarily long hold.
- Long/repeat timing, with t0 = the btn_press cycle:
  - btn_long fires at t0+LONG_CNT, provided btn_level is still 1 in that cycle.
  - btn_repeat fires at t0+LONG_CNT+k*REPEAT_CNT for k >= 1, while held.
  - No repeat pulses when REPEAT_CNT=0.
- Release at or before t0+LONG_CNT produces no btn_long and no repeat.
- Release clears the hold and repeat counters. The next press restarts timing from its own t0.
- Reset mid-operation: all outputs drop to 0 immediately. After rst deasserts, a button still held produces btn_press CNT_MAX+2 cycles later, with full long/repeat timing from that new t0.
- Reset deassertion on a held button never produces a spurious btn_release.
- All outputs are registered; no combinational path from btn_in to any output.

Test Plan:
- Bench parameters: N_CH=2, CNT_MAX=4, LONG_CNT=20, REPEAT_CNT=8, ACTIVE_LOW=2'b10.
- Clean press on ch0, btn_in[0] 0->1 held 10 cycles -> btn_level[0] rises after edge 6; btn_press[0]=1 for that one cycle; btn_long[0] stays 0.
- Bounce on ch0, btn_in[0] toggling high 3 cycles / low 1 cycle repeatedly -> btn_level[0] stays 0, no pulses. Then hold high 6 cycles -> level rises CNT_MAX+2 cycles after the final toggle.
- Long hold on ch0 for 50 cycles after t0 -> btn_long at t0+20; btn_repeat at t0+28, t0+36 and t0+44. Release -> btn_release one cycle; no further repeats.
- Active-low on ch1, btn_in[1] 1->0 -> btn_level[1]=1 and btn_press[1] pulse. Concurrent ch0 activity gives independent, uncorrupted timing on each channel.
- Reset mid-hold, rst pulsed at t0+15 with ch0 still held -> all outputs 0 at once; no btn_release. btn_press[0] again 6 cycles after rst deasserts; btn_long at new t0+20.
- Release exactly at t0+20, btn_level low in cycle t0+20 -> btn_long never asserts; btn_release pulses.
